// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_ctrl_pkg
// Brief    : Shared types and constants for the SR latch pulse front-end.
// Revision : 1.0
// ============================================================================
package sr_ctrl_pkg;

    localparam int unsigned c_debounce_cycles_def = 16;
    localparam int unsigned c_holdoff_cycles_def  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : sr_debounce_chan
// Brief    : Button synchroniser, debounce filter and one-cycle rise request.
// Revision : 1.0
// ============================================================================
module sr_debounce_chan
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_def
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_req
);

    localparam int unsigned     c_cw   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cw-1:0] c_last = c_cw'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic [c_cw-1:0] r_cnt;

    // The counter flips the level on the cycle it would reach DEBOUNCE_CYCLES,
    // so it never holds that value and can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_req = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/sr_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_ctrl
// Brief    : Debounced set/reset buttons -> single-cycle S/R/enable strobes.
// Revision : 1.0
// ============================================================================
module sr_pulse_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_def,
    parameter int unsigned HOLDOFF_CYCLES  = c_holdoff_cycles_def
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic S,
    output logic R,
    output logic enable,
    output logic busy
);

    localparam int unsigned     c_hw        = cnt_width(HOLDOFF_CYCLES);
    localparam logic [c_hw-1:0] c_hold_last = c_hw'(HOLDOFF_CYCLES - 1);

    logic            w_req_s;
    logic            w_req_r;
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_pend_s;
    logic            r_pend_r;
    logic            w_pend_s_nxt;
    logic            w_pend_r_nxt;
    logic [c_hw-1:0] r_hcnt;
    logic [c_hw-1:0] w_hcnt_nxt;

    sr_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_set (
        .clk   (clk),
        .rst   (rst),
        .i_btn (set_btn),
        .o_req (w_req_s)
    );

    sr_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_reset (
        .clk   (clk),
        .rst   (rst),
        .i_btn (reset_btn),
        .o_req (w_req_r)
    );

    // New requests always land in the pending bits, even in the cycle that
    // services the channel; only previously queued requests are consumed.
    always_comb begin
        w_state_nxt  = r_state;
        w_pend_s_nxt = r_pend_s | w_req_s;
        w_pend_r_nxt = r_pend_r | w_req_r;
        w_hcnt_nxt   = r_hcnt;
        case (r_state)
            IDLE: begin
                if (r_pend_r) begin
                    w_state_nxt = PULSE_R;
                end else if (r_pend_s) begin
                    w_state_nxt = PULSE_S;
                end
            end
            PULSE_S: begin
                w_pend_s_nxt = w_req_s;
                w_hcnt_nxt   = '0;
                w_state_nxt  = HOLDOFF;
            end
            PULSE_R: begin
                w_pend_s_nxt = w_req_s;
                w_pend_r_nxt = w_req_r;
                w_hcnt_nxt   = '0;
                w_state_nxt  = HOLDOFF;
            end
            HOLDOFF: begin
                if (r_hcnt == c_hold_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pend_s <= 1'b0;
            r_pend_r <= 1'b0;
            r_hcnt   <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            enable   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend_s <= w_pend_s_nxt;
            r_pend_r <= w_pend_r_nxt;
            r_hcnt   <= w_hcnt_nxt;
            S        <= (w_state_nxt == PULSE_S);
            R        <= (w_state_nxt == PULSE_R);
            enable   <= (w_state_nxt == PULSE_S) || (w_state_nxt == PULSE_R);
            busy     <= (w_state_nxt != IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_pulse_ctrl
// Brief    : Directed + random bench for three parameterisations of sr_pulse_ctrl.
// Revision : 1.0
// ============================================================================
module tb_sr_pulse_ctrl;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       set_btn   = 1'b0;
    logic       reset_btn = 1'b0;
    logic [2:0] dut_s;
    logic [2:0] dut_r;
    logic [2:0] dut_en;
    logic [2:0] dut_busy;

    always #5 clk = ~clk;

    sr_pulse_ctrl u_dut0 (
        .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
        .S(dut_s[0]), .R(dut_r[0]), .enable(dut_en[0]), .busy(dut_busy[0])
    );
    sr_pulse_ctrl #(.DEBOUNCE_CYCLES(2), .HOLDOFF_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
        .S(dut_s[1]), .R(dut_r[1]), .enable(dut_en[1]), .busy(dut_busy[1])
    );
    sr_pulse_ctrl #(.DEBOUNCE_CYCLES(255), .HOLDOFF_CYCLES(4)) u_dut2 (
        .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
        .S(dut_s[2]), .R(dut_r[2]), .enable(dut_en[2]), .busy(dut_busy[2])
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit run_chk  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: debounce = "last D synchronised samples all differ
    // from the accepted level"; arbiter = pending flags plus the earliest
    // edge at which the next strobe may be issued.
    // ------------------------------------------------------------------
    int   pd[3] = '{16, 2, 255};
    int   ph[3] = '{4, 1, 4};
    int   edge_n = 0;
    bit   m_p1[3][2];
    bit   m_p2[3][2];
    bit   m_lvl[3][2];
    bit   m_rose[3][2];
    bit   m_hist[3][2][256];
    bit   m_pend_s[3];
    bit   m_pend_r[3];
    int   m_free_at[3];
    int   m_busy_end[3];
    int   m_prev_kind[3];
    logic [3:0] m_exp[3];

    function automatic void model_step(input int i, input bit raw_s, input bit raw_r, input bit x_rst);
        int kind;
        bit raw[2];
        bit diff;
        raw[0] = raw_s;
        raw[1] = raw_r;
        if (x_rst) begin
            for (int c = 0; c < 2; c++) begin
                m_p1[i][c] = 0; m_p2[i][c] = 0; m_lvl[i][c] = 0; m_rose[i][c] = 0;
                for (int k = 0; k < 256; k++) m_hist[i][c][k] = 0;
            end
            m_pend_s[i] = 0; m_pend_r[i] = 0;
            m_free_at[i] = 0; m_busy_end[i] = -1; m_prev_kind[i] = 0;
            m_exp[i] = 4'b0000;
            return;
        end
        kind = 0;
        if (edge_n >= m_free_at[i]) kind = m_pend_r[i] ? 2 : (m_pend_s[i] ? 1 : 0);
        if (m_prev_kind[i] == 2) begin
            m_pend_r[i] = 0; m_pend_s[i] = 0;
        end else if (m_prev_kind[i] == 1) begin
            m_pend_s[i] = 0;
        end
        m_pend_s[i] = m_pend_s[i] | m_rose[i][0];
        m_pend_r[i] = m_pend_r[i] | m_rose[i][1];
        if (kind != 0) begin
            m_free_at[i]  = edge_n + 2 + ph[i];
            m_busy_end[i] = edge_n + ph[i];
        end
        m_prev_kind[i] = kind;
        for (int c = 0; c < 2; c++) begin
            for (int k = 255; k > 0; k--) m_hist[i][c][k] = m_hist[i][c][k-1];
            m_hist[i][c][0] = m_p2[i][c];
            diff = 1;
            for (int k = 0; k < pd[i]; k++) if (m_hist[i][c][k] == m_lvl[i][c]) diff = 0;
            m_rose[i][c] = 0;
            if (diff) begin
                m_lvl[i][c]  = !m_lvl[i][c];
                m_rose[i][c] = m_lvl[i][c];
            end
            m_p2[i][c] = m_p1[i][c];
            m_p1[i][c] = raw[c];
        end
        m_exp[i] = {kind == 1, kind == 2, kind != 0, edge_n <= m_busy_end[i]};
    endfunction

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 3; i++) model_step(i, set_btn, reset_btn, rst);
    end

    always @(negedge clk) begin
        if (run_chk) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("model_inst%0d", i),
                      {28'd0, dut_s[i], dut_r[i], dut_en[i], dut_busy[i]}, {28'd0, m_exp[i]});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic s, input logic r, input logic x);
        set_btn   = s;
        reset_btn = r;
        rst       = x;
        @(posedge clk);
        #1;
    endtask

    int t0;
    int lat[3];
    int cnt_s;
    int cnt_r;
    int cnt_any;
    int cnt_busy;
    int es;
    int er;
    bit q0;

    task automatic upd_q0();
        if (dut_r[0]) q0 = 1'b0;
        else if (dut_s[0]) q0 = 1'b1;
    endtask

    initial begin
        q0 = 1'b0;
        drive(0, 0, 1);
        run_chk = 1'b1;
        drive(0, 0, 1);
        drive(0, 0, 1);
        check("reset_outputs", {20'd0, dut_s, dut_r, dut_en, dut_busy}, 32'd0);
        drive(0, 0, 0);

        // Clean press, long enough for every parameterisation.
        t0 = edge_n + 1;
        for (int i = 0; i < 3; i++) lat[i] = -1;
        cnt_s = 0; cnt_busy = 0;
        for (int k = 0; k < 300; k++) begin
            drive(1, 0, 0);
            upd_q0();
            for (int i = 0; i < 3; i++) if (dut_s[i] && lat[i] < 0) lat[i] = edge_n - t0;
            if (dut_s[0]) cnt_s++;
            if (dut_busy[0]) cnt_busy++;
        end
        for (int i = 0; i < 3; i++) check($sformatf("latency_inst%0d", i), lat[i], pd[i] + 3);
        check("press_single_s", cnt_s, 1);
        check("press_busy_len", cnt_busy, 5);
        check("press_latch_q", {31'd0, q0}, 1);
        for (int k = 0; k < 300; k++) drive(0, 0, 0);

        // Bounce shorter than the default debounce window.
        cnt_any = 0;
        for (int k = 0; k < 52; k++) begin
            drive((k < 12) ? (((k / 3) % 2) == 0) : 1'b0, 0, 0);
            if (dut_s[0] || dut_r[0] || dut_en[0]) cnt_any++;
        end
        check("bounce_no_strobe", cnt_any, 0);

        // Simultaneous press: reset wins, set discarded.
        cnt_s = 0; cnt_r = 0;
        for (int k = 0; k < 60; k++) begin
            drive(k < 30, k < 30, 0);
            upd_q0();
            if (dut_s[0]) cnt_s++;
            if (dut_r[0]) cnt_r++;
        end
        check("simul_r_count", cnt_r, 1);
        check("simul_s_count", cnt_s, 0);
        check("simul_latch_q", {31'd0, q0}, 0);
        for (int k = 0; k < 300; k++) drive(0, 0, 0);

        // Reset request lands two cycles into the holdoff window.
        t0 = edge_n + 1;
        es = -1; er = -1;
        for (int k = 0; k < 60; k++) begin
            drive(1, k >= 4, 0);
            if (dut_s[0] && es < 0) es = edge_n;
            if (dut_r[0] && er < 0) er = edge_n;
        end
        check("holdoff_s_latency", es - t0, 19);
        check("holdoff_r_spacing", er - es, 6);
        for (int k = 0; k < 300; k++) drive(0, 0, 0);

        // rst at debounce count 10 while the button stays held.
        for (int k = 0; k < 12; k++) drive(1, 0, 0);
        drive(1, 0, 1);
        check("midrst_outputs", {20'd0, dut_s, dut_r, dut_en, dut_busy}, 32'd0);
        t0 = edge_n + 1;
        lat[0] = -1;
        for (int k = 0; k < 40; k++) begin
            drive(1, 0, 0);
            if (dut_s[0] && lat[0] < 0) lat[0] = edge_n - t0;
        end
        check("midrst_latency", lat[0], 19);
        for (int k = 0; k < 300; k++) drive(0, 0, 0);

        // Random segments with occasional glitches and resets.
        for (int seg = 0; seg < 80; seg++) begin
            logic sv;
            logic rv;
            int   len;
            sv  = 1'($urandom_range(0, 1));
            rv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(1, 30));
            for (int k = 0; k < len; k++) begin
                logic gs;
                gs = ($urandom_range(0, 19) == 0) ? ~sv : sv;
                drive(gs, rv, $urandom_range(0, 99) < 2);
            end
        end
        for (int k = 0; k < 300; k++) drive(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
